// File: rtl/btn_pkg.sv
// Shared types and sizing helpers for the push-button conditioner.
package btn_pkg;

  // Per-channel auto-repeat controller states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rep_state_t;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    if (max_val < 1) begin
      return 1;
    end else begin
      return $clog2(max_val + 1);
    end
  endfunction

  // Larger of two integers, used to size a counter shared by two limits.
  function automatic int max2(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: two-flop synchroniser, stability-counter debounce,
// registered press/release pulses and a typematic auto-repeat FSM.
// "release" and "repeat" are language keywords, so those outputs carry a
// _pulse suffix.
module btn_channel
  import btn_pkg::*;
#(
  parameter int STABLE_CYC = 16,
  parameter int REPEAT_DLY = 20,
  parameter int REPEAT_PER = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  input  logic repeat_en,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int CW = cnt_width(STABLE_CYC);
  localparam int RW = cnt_width(max2(REPEAT_DLY, REPEAT_PER));

  logic          sync1;
  logic          s;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] cnt_next;
  logic          toggle;
  logic          rise;
  logic          fall;

  rep_state_t    state;
  rep_state_t    state_next;
  logic [RW-1:0] rcnt;
  logic [RW-1:0] rcnt_next;
  logic          rpt_next;
  logic          exit_rep;

  // Bring the asynchronous pin into the clock domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
    end else begin
      sync1 <= btn_in;
      s     <= sync1;
    end
  end

  // Count consecutive disagreeing samples; any agreeing sample restarts the window.
  always_comb begin
    cnt_inc  = cnt + CW'(1);
    toggle   = 1'b0;
    cnt_next = {CW{1'b0}};
    if (s != level) begin
      if (cnt_inc == CW'(STABLE_CYC)) begin
        toggle = 1'b1;
      end else begin
        cnt_next = cnt_inc;
      end
    end else begin
      cnt_next = {CW{1'b0}};
    end
    rise = toggle & ~level;
    fall = toggle & level;
  end

  // Debounced level and edge pulses, registered so pulses coincide with the level change.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= {CW{1'b0}};
      level         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      cnt           <= cnt_next;
      level         <= level ^ toggle;
      press         <= rise;
      release_pulse <= fall;
    end
  end

  // Repeat FSM state register, with its counter and registered repeat output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rcnt         <= {RW{1'b0}};
      repeat_pulse <= 1'b0;
    end else begin
      state        <= state_next;
      rcnt         <= rcnt_next;
      repeat_pulse <= rpt_next;
    end
  end

  // Repeat FSM next state: start only on a fresh press, leave on release or enable drop.
  always_comb begin
    exit_rep   = fall | ~repeat_en;
    state_next = state;
    case (state)
      IDLE: begin
        if (rise && repeat_en) begin
          state_next = DELAY;
        end else begin
          state_next = IDLE;
        end
      end
      DELAY: begin
        if (exit_rep) begin
          state_next = IDLE;
        end else if (rcnt == RW'(REPEAT_DLY)) begin
          state_next = REPEAT;
        end else begin
          state_next = DELAY;
        end
      end
      REPEAT: begin
        if (exit_rep) begin
          state_next = IDLE;
        end else begin
          state_next = REPEAT;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Repeat FSM outputs: counter update and repeat request; exit suppresses the pulse.
  always_comb begin
    rcnt_next = {RW{1'b0}};
    rpt_next  = 1'b0;
    case (state)
      IDLE: begin
        if (rise && repeat_en) begin
          rcnt_next = RW'(1);
        end else begin
          rcnt_next = {RW{1'b0}};
        end
      end
      DELAY: begin
        if (exit_rep) begin
          rcnt_next = {RW{1'b0}};
        end else if (rcnt == RW'(REPEAT_DLY)) begin
          rpt_next  = 1'b1;
          rcnt_next = RW'(1);
        end else begin
          rcnt_next = rcnt + RW'(1);
        end
      end
      REPEAT: begin
        if (exit_rep) begin
          rcnt_next = {RW{1'b0}};
        end else if (rcnt == RW'(REPEAT_PER)) begin
          rpt_next  = 1'b1;
          rcnt_next = RW'(1);
        end else begin
          rcnt_next = rcnt + RW'(1);
        end
      end
      default: begin
        rcnt_next = {RW{1'b0}};
        rpt_next  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel push-button conditioner: N_CH independent btn_channel copies.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int N_CH       = 5,
  parameter int STABLE_CYC = 16,
  parameter int REPEAT_DLY = 20,
  parameter int REPEAT_PER = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_in,
  input  logic [N_CH-1:0] repeat_en,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] repeat_pulse
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    btn_channel #(
      .STABLE_CYC (STABLE_CYC),
      .REPEAT_DLY (REPEAT_DLY),
      .REPEAT_PER (REPEAT_PER)
    ) u_ch (
      .clk           (clk),
      .rst           (rst),
      .btn_in        (btn_in[i]),
      .repeat_en     (repeat_en[i]),
      .level         (level[i]),
      .press         (press[i]),
      .release_pulse (release_pulse[i]),
      .repeat_pulse  (repeat_pulse[i])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with N_CH=4, STABLE_CYC=4,
// REPEAT_DLY=10, REPEAT_PER=3. Expected event edges are hand-computed.
module tb_btn_conditioner;

  localparam int N_CH = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N_CH-1:0] btn_in;
  logic [N_CH-1:0] repeat_en;
  logic [N_CH-1:0] level;
  logic [N_CH-1:0] press;
  logic [N_CH-1:0] release_pulse;
  logic [N_CH-1:0] repeat_pulse;

  int n_pass  = 0;
  int n_total = 0;

  logic [N_CH-1:0] exp_level;
  logic [N_CH-1:0] exp_press;
  logic [N_CH-1:0] exp_rel;
  logic [N_CH-1:0] exp_rpt;
  logic [4:0]      ch2_pat;

  btn_conditioner #(
    .N_CH       (N_CH),
    .STABLE_CYC (4),
    .REPEAT_DLY (10),
    .REPEAT_PER (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_in        (btn_in),
    .repeat_en     (repeat_en),
    .level         (level),
    .press         (press),
    .release_pulse (release_pulse),
    .repeat_pulse  (repeat_pulse)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input int e,
                       input logic [N_CH-1:0] obs, input logic [N_CH-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s edge %0d: observed %b expected %b", tag, e, obs, exp);
  endtask

  task automatic check_all(input string phase, input int e);
    check({phase, ".level"},   e, level,         exp_level);
    check({phase, ".press"},   e, press,         exp_press);
    check({phase, ".release"}, e, release_pulse, exp_rel);
    check({phase, ".repeat"},  e, repeat_pulse,  exp_rpt);
  endtask

  // Directed stimulus: edge e is the posedge that samples the inputs set just before it.
  initial begin
    rst       = 1'b1;
    btn_in    = 4'b0000;
    repeat_en = 4'b0000;
    ch2_pat   = 5'b01101;   // ch2 samples at edges 0..4: 1,0,1,1,0
    @(posedge clk); #1;
    @(posedge clk); #1;
    exp_level = 4'b0000; exp_press = 4'b0000; exp_rel = 4'b0000; exp_rpt = 4'b0000;
    check_all("reset", -1);
    rst = 1'b0;

    // Phase 1: clean press (ch0), glitch (ch1), bounce (ch2), repeat+release (ch3).
    for (int e = 0; e <= 30; e++) begin
      btn_in[0] = 1'b1;
      btn_in[1] = (e < 3);
      btn_in[2] = (e < 5) ? ch2_pat[e] : 1'b1;
      btn_in[3] = (e < 19);
      repeat_en = 4'b1000;
      @(posedge clk); #1;
      exp_level = {(e >= 5 && e < 24), (e >= 10), 1'b0, (e >= 5)};
      exp_press = {(e == 5), (e == 10), 1'b0, (e == 5)};
      exp_rel   = {(e == 24), 1'b0, 1'b0, 1'b0};
      exp_rpt   = {(e == 15 || e == 18 || e == 21), 1'b0, 1'b0, 1'b0};
      check_all("p1", e);
    end

    // Let every channel settle back to idle.
    btn_in    = 4'b0000;
    repeat_en = 4'b0000;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
    end
    exp_level = 4'b0000;
    check("settle.level", -1, level, exp_level);

    // Phase 2: ch0 repeats, enable drops at edge 17, re-raised at 20, reset at edge 30.
    for (int e = 0; e <= 45; e++) begin
      btn_in       = 4'b0001;
      repeat_en    = 4'b0000;
      repeat_en[0] = (e < 17 || e >= 20);
      rst          = (e == 30);
      @(posedge clk); #1;
      exp_level = {3'b000, ((e >= 5 && e < 30) || e >= 36)};
      exp_press = {3'b000, (e == 5 || e == 36)};
      exp_rel   = 4'b0000;
      exp_rpt   = {3'b000, (e == 15)};
      check_all("p2", e);
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
